ccl_stream: RTL

CCL_STREAM -- requirements
Module: ccl_stream

---
 rtl/ccl_stream.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/ccl_stream.sv
// ccl_stream: streaming 8-connected component labeller with per-blob area, emitted after each frame.
// Bounding-box tracking is built only when CCL_BBOX_EN is defined.
module ccl_stream #(
   parameter int WIDTH = 320,
   parameter int HEIGHT = 180,
   parameter int MAX_LABELS = 32,
   parameter int MIN_AREA = 50,
   localparam int LW = $clog2(MAX_LABELS + 1)
) (
   input  logic          clk_in,
   input  logic          rst_n_in,
   input  logic          valid_in,
   output logic          ready_out,
   input  logic          new_frame_in,
   input  logic          mask_in,
   input  logic [10:0]   x_in,
   input  logic [9:0]    y_in,
   output logic          blob_valid_out,
   input  logic          blob_ready_in,
   output logic [16:0]   blob_area_out,
   output logic [10:0]   blob_xmin_out,
   output logic [10:0]   blob_xmax_out,
   output logic [9:0]    blob_ymin_out,
   output logic [9:0]    blob_ymax_out,
   output logic          frame_done_out,
   output logic [LW-1:0] num_blobs_out,
   output logic          overflow_out
);
   localparam logic [1:0] IDLE = 2'd0, LABEL = 2'd1, EMIT = 2'd2, DONE = 2'd3;
   localparam int XW = $clog2(WIDTH);
   localparam logic [LW:0] ML = (LW+1)'(MAX_LABELS);

   logic [1:0]    r_state, w_ns;
   logic          r_rdy, r_ovf, r_bv;
   logic [LW-1:0] r_par [0:MAX_LABELS];
   logic [16:0]   r_area [0:MAX_LABELS];
   logic [LW-1:0] r_line [0:WIDTH-1];
   logic [LW-1:0] r_w, r_nw, r_num;
   logic [LW:0]   r_next, r_scan, w_nxt;
   logic [16:0]   r_barea, w_amrg;
   logic [17:0]   w_asum;
   logic [10:0]   w_x;
   logic [9:0]    w_y;
   logic [XW-1:0] w_xi, w_nei;
   logic [LW-1:0] w_nb [4];
   logic [LW-1:0] w_mn, w_mx, w_lab, w_ni, w_sl;
   logic          w_pix, w_last, w_hw, w_hn, w_he, w_any, w_mrg, w_free, w_adv, w_q, w_load;

   assign w_pix  = valid_in && r_rdy && (new_frame_in || r_state == LABEL);
   assign w_x    = new_frame_in ? '0 : x_in;
   assign w_y    = new_frame_in ? '0 : y_in;
   assign w_xi   = w_x[XW-1:0];
   assign w_last = w_x == 11'(WIDTH - 1) && w_y == 10'(HEIGHT - 1);
   assign w_hw   = w_x != '0;
   assign w_hn   = w_y != '0;
   assign w_he   = w_x != 11'(WIDTH - 1);
   assign w_nei  = w_he ? w_xi + 1'b1 : w_xi;
   // NW comes from r_nw because line[x-1] already holds this row's W label
   assign w_nb[0] = w_hw ? r_par[r_w] : '0;
   assign w_nb[1] = (w_hw && w_hn) ? r_par[r_nw] : '0;
   assign w_nb[2] = w_hn ? r_par[r_line[w_xi]] : '0;
   assign w_nb[3] = (w_hn && w_he) ? r_par[r_line[w_nei]] : '0;

   always_comb begin
      w_mn = '1;
      w_mx = '0;
      for (int i = 0; i < 4; i++) begin
         w_mn = (|w_nb[i] && w_nb[i] < w_mn) ? w_nb[i] : w_mn;
         w_mx = (w_nb[i] > w_mx) ? w_nb[i] : w_mx;
      end
   end

   assign w_any  = |w_mx;
   assign w_mrg  = w_any && w_mx != w_mn;
   assign w_nxt  = new_frame_in ? (LW+1)'(1) : r_next;
   assign w_ni   = w_nxt[LW-1:0];
   assign w_free = w_nxt <= ML;
   assign w_lab  = !mask_in ? '0 : w_any ? w_mn : w_free ? w_ni : '0;
   assign w_asum = 18'(r_area[w_mn]) + (w_mrg ? 18'(r_area[w_mx]) : 18'd0) + 18'd1;
   assign w_amrg = w_asum[17] ? '1 : w_asum[16:0];
   assign w_sl   = r_scan[LW-1:0];
   assign w_adv  = r_state == EMIT && (!r_bv || blob_ready_in);
   assign w_q    = r_scan <= ML && r_par[w_sl] == w_sl && r_area[w_sl] >= 17'(MIN_AREA);
   assign w_load = w_adv && w_q;

   always_comb begin
      w_ns = r_state;
      if (w_pix) w_ns = w_last ? EMIT : LABEL;
      else if (w_adv && r_scan > ML) w_ns = DONE;
      else if (r_state == DONE) w_ns = IDLE;
   end

   always_ff @(posedge clk_in)
      if (w_pix) r_line[w_xi] <= w_lab;

   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) begin
         r_state <= IDLE;
         r_rdy   <= 1'b0;
         r_ovf   <= 1'b0;
         r_bv    <= 1'b0;
         r_next  <= (LW+1)'(1);
         r_scan  <= (LW+1)'(1);
         r_num   <= '0;
         r_barea <= '0;
         r_w     <= '0;
         r_nw    <= '0;
         for (int i = 0; i <= MAX_LABELS; i++) begin
            r_par[i]  <= '0;
            r_area[i] <= '0;
         end
      end else begin
         r_state <= w_ns;
         r_rdy   <= w_ns == IDLE || w_ns == LABEL;
         if (w_pix) begin
            if (new_frame_in) begin
               r_ovf  <= 1'b0;
               r_num  <= '0;
               r_scan <= (LW+1)'(1);
               r_next <= (LW+1)'(1);
               for (int i = 0; i <= MAX_LABELS; i++) begin
                  r_par[i]  <= '0;
                  r_area[i] <= '0;
               end
            end
            r_w  <= w_lab;
            r_nw <= r_line[w_xi];
            if (mask_in && w_any) begin
               r_area[w_mn] <= w_amrg;
               if (w_mrg) begin
                  r_area[w_mx] <= '0;
                  for (int i = 0; i <= MAX_LABELS; i++)
                     if (r_par[i] == w_mx) r_par[i] <= w_mn;
               end
            end else if (mask_in && w_free) begin
               r_par[w_ni]  <= w_ni;
               r_area[w_ni] <= 17'd1;
               r_next       <= w_nxt + 1'b1;
            end else if (mask_in) r_ovf <= 1'b1;
         end
         if (w_adv) begin
            r_bv <= w_q;
            if (w_q) begin
               r_barea <= r_area[w_sl];
               r_num   <= r_num + 1'b1;
            end
            if (r_scan <= ML) r_scan <= r_scan + 1'b1;
         end
      end

`ifdef CCL_BBOX_EN
   logic [10:0] r_x0 [0:MAX_LABELS], r_x1 [0:MAX_LABELS];
   logic [9:0]  r_y0 [0:MAX_LABELS], r_y1 [0:MAX_LABELS];
   logic [10:0] r_bx0, r_bx1, w_ux0, w_ux1;
   logic [9:0]  r_by0, r_by1, w_uy0, w_uy1;

   always_comb begin
      w_ux0 = r_x0[w_mn] < w_x ? r_x0[w_mn] : w_x;
      w_ux1 = r_x1[w_mn] > w_x ? r_x1[w_mn] : w_x;
      w_uy0 = r_y0[w_mn] < w_y ? r_y0[w_mn] : w_y;
      w_uy1 = r_y1[w_mn] > w_y ? r_y1[w_mn] : w_y;
      w_ux0 = (w_mrg && r_x0[w_mx] < w_ux0) ? r_x0[w_mx] : w_ux0;
      w_ux1 = (w_mrg && r_x1[w_mx] > w_ux1) ? r_x1[w_mx] : w_ux1;
      w_uy0 = (w_mrg && r_y0[w_mx] < w_uy0) ? r_y0[w_mx] : w_uy0;
      w_uy1 = (w_mrg && r_y1[w_mx] > w_uy1) ? r_y1[w_mx] : w_uy1;
   end

   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) begin
         r_bx0 <= '0;
         r_bx1 <= '0;
         r_by0 <= '0;
         r_by1 <= '0;
         for (int i = 0; i <= MAX_LABELS; i++) begin
            r_x0[i] <= '0;
            r_x1[i] <= '0;
            r_y0[i] <= '0;
            r_y1[i] <= '0;
         end
      end else begin
         if (w_pix) begin
            if (new_frame_in)
               for (int i = 0; i <= MAX_LABELS; i++) begin
                  r_x0[i] <= '0;
                  r_x1[i] <= '0;
                  r_y0[i] <= '0;
                  r_y1[i] <= '0;
               end
            if (mask_in && w_any) begin
               r_x0[w_mn] <= w_ux0;
               r_x1[w_mn] <= w_ux1;
               r_y0[w_mn] <= w_uy0;
               r_y1[w_mn] <= w_uy1;
               if (w_mrg) begin
                  r_x0[w_mx] <= '0;
                  r_x1[w_mx] <= '0;
                  r_y0[w_mx] <= '0;
                  r_y1[w_mx] <= '0;
               end
            end else if (mask_in && w_free) begin
               r_x0[w_ni] <= w_x;
               r_x1[w_ni] <= w_x;
               r_y0[w_ni] <= w_y;
               r_y1[w_ni] <= w_y;
            end
         end
         if (w_load) begin
            r_bx0 <= r_x0[w_sl];
            r_bx1 <= r_x1[w_sl];
            r_by0 <= r_y0[w_sl];
            r_by1 <= r_y1[w_sl];
         end
      end

   assign blob_xmin_out = r_bx0;
   assign blob_xmax_out = r_bx1;
   assign blob_ymin_out = r_by0;
   assign blob_ymax_out = r_by1;
`else
   assign blob_xmin_out = '0;
   assign blob_xmax_out = '0;
   assign blob_ymin_out = '0;
   assign blob_ymax_out = '0;
`endif

   assign ready_out      = r_rdy;
   assign blob_valid_out = r_bv;
   assign blob_area_out  = r_barea;
   assign frame_done_out = r_state == DONE;
   assign num_blobs_out  = r_num;
   assign overflow_out   = r_ovf;
endmodule
